// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // One fetch-queue slot: address of the request and, once returned, its instruction.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue: allocate at tail, fill oldest unfilled, pop at head, flush all.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned  DEPTH = 2,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_alloc,
  input  logic [31:0]   i_alloc_pc,
  input  logic          i_fill,
  input  logic [31:0]   i_fill_data,
  input  logic          i_pop,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_unfilled,
  output fetch_entry_t  o_head
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_head, r_tail, r_fill;
  logic [CW-1:0] r_count, r_nfilled;
  logic          w_alloc_en, w_fill_en, w_pop_en;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Qualify requests: a full queue may still allocate into the slot freed by this cycle's pop.
  always_comb begin
    w_pop_en   = i_pop && (r_nfilled != '0);
    w_fill_en  = i_fill && (r_count != r_nfilled);
    w_alloc_en = i_alloc && ((r_count != CW'(DEPTH)) || w_pop_en);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_fill    <= '0;
      r_count   <= '0;
      r_nfilled <= '0;
    end else if (i_flush) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_fill    <= '0;
      r_count   <= '0;
      r_nfilled <= '0;
    end else begin
      if (w_alloc_en) r_tail <= ptr_inc(r_tail);
      if (w_fill_en)  r_fill <= ptr_inc(r_fill);
      if (w_pop_en)   r_head <= ptr_inc(r_head);
      r_count   <= r_count + CW'(w_alloc_en) - CW'(w_pop_en);
      r_nfilled <= r_nfilled + CW'(w_fill_en) - CW'(w_pop_en);
    end
  end

  // Entry storage; alloc and fill never target the same slot in one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i].filled <= 1'b0;
    end else begin
      if (w_alloc_en) begin
        r_mem[r_tail].pc     <= i_alloc_pc;
        r_mem[r_tail].instr  <= '0;
        r_mem[r_tail].filled <= 1'b0;
      end
      if (w_fill_en) begin
        r_mem[r_fill].instr  <= i_fill_data;
        r_mem[r_fill].filled <= 1'b1;
      end
    end
  end

  assign o_count    = r_count;
  assign o_unfilled = r_count - r_nfilled;
  assign o_head     = r_mem[r_head];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, imem request/response handshake, redirect flush.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_if_valid,
  input  logic        i_if_ready,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_drop_cnt;

  logic [CW-1:0] w_count, w_unfilled, w_drop_add;
  logic [CW:0]   w_in_flight;
  fetch_entry_t  w_head;
  logic          w_req_valid, w_alloc, w_rsp_drop, w_rsp_keep, w_rsp_err;
  logic          w_if_valid, w_pop;

  // Handshake decode. Stale in-flight requests still occupy memory slots, so they count
  // against DEPTH; the head leaving this cycle frees its slot for this cycle's request.
  always_comb begin
    w_if_valid  = w_head.filled && (w_count != '0) && !i_redirect_valid;
    w_pop       = w_if_valid && i_if_ready;
    w_in_flight = {1'b0, w_count} - (CW+1)'(w_pop) + {1'b0, r_drop_cnt};
    w_req_valid = i_rst_n && !i_redirect_valid && (w_in_flight < (CW+1)'(DEPTH));
    w_alloc     = w_req_valid && i_imem_req_ready;
    w_rsp_drop  = i_imem_rsp_valid && (r_drop_cnt != '0);
    w_rsp_keep  = i_imem_rsp_valid && (r_drop_cnt == '0) && (w_unfilled != '0);
    w_rsp_err   = i_imem_rsp_valid && (r_drop_cnt == '0) && (w_unfilled == '0);
    // A kept response in the redirect cycle retires one of the entries being flushed.
    w_drop_add  = i_redirect_valid ? (w_unfilled - CW'(w_rsp_keep)) : '0;
  end

  // Next fetch address.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_redirect_valid) begin
      r_pc <= align_pc(i_redirect_pc);
    end else if (w_alloc) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  // Count of responses still owed for flushed requests.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= r_drop_cnt - CW'(w_rsp_drop) + w_drop_add;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_redirect_valid),
    .i_alloc     (w_alloc),
    .i_alloc_pc  (r_pc),
    .i_fill      (w_rsp_keep),
    .i_fill_data (i_imem_rsp_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_unfilled  (w_unfilled),
    .o_head      (w_head)
  );

  assign o_imem_req_valid = w_req_valid;
  assign o_imem_req_addr  = r_pc;
  assign o_if_valid       = w_if_valid;
  assign o_if_pc          = w_head.pc;
  assign o_if_instr       = w_head.instr;

  // A response with nothing to fill and nothing owed means the memory broke the protocol.
  assert property (@(posedge i_clk) disable iff (!i_rst_n) !w_rsp_err);

endmodule
